ip_request_ctrl: RTL and testbench
==================================

// Module: ip_request_ctrl
// PURPOSE
// - Per-input-port request side of the router's round-robin output arbitration.
// - Buffers incoming flits and computes the XY next hop for the head flit.
// - Presents that next hop as a 3-bit request to the five output-port RR processors and waits for a grant.
// - On grant, drives the flit to the crossbar and pulses change_order to the granting arbiter's RR registers.
// - One instance per router input port (N/S/W/E/L).
// PARAMETERS
// DATA_W      32  flit width; dest_x = data[DATA_W-1 -: COORD_W], dest_y = next COORD_W bits below
// COORD_W     3   mesh coordinate width
// DEPTH       4   input FIFO depth, power of two, >= 2
// MY_X        0   this router's X coordinate
// MY_Y        0   this router's Y coordinate
// STALL_LIMIT 15  REQUEST cycles without grant before stall_o asserts
// PORTS
// clk             in   1       single clock, all logic on posedge
// reset           in   1       synchronous, active-high
// data_i          in   DATA_W  flit from upstream link
// valid_i         in   1       data_i valid
// ready_o         out  1       FIFO not full; transfer when valid_i & ready_o
// grant_i         in   5       per-output-port grant to this input, idx N=4,S=3,W=2,E=1,L=0
// nexthop_addr_o  out  3       requested output port (noc_pkg encoding), PORT_NONE when idle
// data_o          out  DATA_W  flit to crossbar
// valid_o         out  1       data_o valid, one cycle per flit
// change_order_o  out  5       one-cycle pulse to the granting arbiter's rr_register_change_order_i
// stall_o         out  1       request outstanding >= STALL_LIMIT cycles
// BEHAVIOUR
// - Port encoding: N=3'd0, S=3'd1, W=3'd2, E=3'd3, L=3'd4, PORT_NONE=3'd7.
// - Reset values:
//   - state=IDLE, FIFO empty, ready_o=1, nexthop_addr_o=PORT_NONE
//   - valid_o=0, data_o=0, change_order_o=0, stall_o=0, stall count=0
//   - reset mid-operation drops the FIFO contents and any in-flight request/send; no change_order pulse is issued.
// - FIFO:
//   - push iff valid_i & ready_o; ready_o = !full, registered pointers with wrap bit.
//   - full is decided before pop, so no push-on-full even when a pop occurs in the same cycle.
//   - pointers wrap modulo DEPTH.
// - Route (XY, from the head flit):
//   - dest_x > MY_X -> E; dest_x < MY_X -> W.
//   - otherwise dest_y > MY_Y -> N; dest_y < MY_Y -> S; else L.
//   - unsigned compare; route registered into route_q.
// - State machine:
//   - IDLE: nexthop_addr_o=PORT_NONE. If FIFO non-empty, load route_q from the head and go to REQUEST.
//   - REQUEST: nexthop_addr_o=route_q.
//     - grant_i[idx(route_q)]=1 -> SEND.
//     - grant bits for other ports are ignored.
//     - stall counter increments per cycle without grant, saturates at STALL_LIMIT; stall_o = (count==STALL_LIMIT).
//   - SEND: valid_o=1, data_o=head, change_order_o[idx(route_q)]=1, FIFO pop, counter cleared, nexthop_addr_o=PORT_NONE; always -> IDLE.
// - Timing:
//   - flit accepted at edge e0 -> request visible cycle e1+ -> same-cycle grant -> valid_o in the cycle after e2.
//   - Minimum 3 cycles per flit; back-to-back flits repeat IDLE->REQUEST->SEND.
// - valid_o and change_order_o are registered state decodes with no combinational path from grant_i.
// - nexthop_addr_o is registered. grant_i is sampled only in REQUEST.
// - A simultaneous push while in SEND is accepted if not full; the head pointer advances exactly once.
// STRUCTURE
// - noc_pkg (shared):
//   - port_e encodings N/S/W/E/L/PORT_NONE
//   - port-to-grant-index function
//   - ip_state_e {IDLE, REQUEST, SEND}
//   - COORD_W default
// - Sub-module ip_flit_fifo (sync FIFO: DATA_W, DEPTH; push/pop/full/empty/head).
// - Route compute, FSM, and stall counter live in the top level.
// TESTING
// - MY=(1,1), push dest (3,1), grant_i[1] in first REQUEST cycle -> nexthop=3'd3, valid_o one cycle later, change_order_o=5'b00010 for one cycle.
// - Push dest (1,1) -> nexthop=3'd4; grant_i=5'b00010 (wrong port) held 5 cycles -> stays REQUEST, no valid_o; then grant_i[0] -> SEND, change_order_o=5'b00001.
// - DEPTH=4: push 5 flits with no grant -> ready_o=0 after the 4th; the 5th is held upstream; grant drains all in order, 3 cycles apart.
// - No grant for 15 REQUEST cycles -> stall_o=1 on the 15th, stays 1 until SEND, then 0.
// - Reset asserted in REQUEST with 2 flits queued -> next cycle nexthop=3'd7, ready_o=1, no valid_o/change_order, FIFO empty.
// - Push and SEND-pop in the same cycle with FIFO holding 3 -> count stays 3, data order preserved.

Source files
------------

// File: rtl/ip_request_ctrl_pkg.sv
// Shared router definitions: output-port encodings, grant indexing and the
// input-port request FSM states.
package ip_request_ctrl_pkg;

    localparam int COORD_W_DEF = 3;

    typedef enum logic [2:0] {
        PORT_N    = 3'd0,
        PORT_S    = 3'd1,
        PORT_W    = 3'd2,
        PORT_E    = 3'd3,
        PORT_L    = 3'd4,
        PORT_NONE = 3'd7
    } port_e;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        SEND
    } ip_state_e;

    // Grant/change_order vectors are indexed N=4, S=3, W=2, E=1, L=0.
    function automatic logic [2:0] port_to_idx(port_e p);
        logic [2:0] idx;
        case (p)
            PORT_N:  idx = 3'd4;
            PORT_S:  idx = 3'd3;
            PORT_W:  idx = 3'd2;
            PORT_E:  idx = 3'd1;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [4:0] port_onehot(port_e p);
        logic [4:0] vec;
        vec = 5'b00000;
        if (p inside {PORT_N, PORT_S, PORT_W, PORT_E, PORT_L}) begin
            vec[port_to_idx(p)] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/ip_request_ctrl_if.sv
// Link/crossbar/arbiter signal bundle of one router input port.
interface ip_request_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic [4:0]        grant_i;
    logic [2:0]        nexthop_addr_o;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic [4:0]        change_order_o;
    logic              stall_o;

    modport slave (
        input  data_i, valid_i, grant_i,
        output ready_o, nexthop_addr_o, data_o, valid_o, change_order_o, stall_o
    );

    modport master (
        output data_i, valid_i, grant_i,
        input  ready_o, nexthop_addr_o, data_o, valid_o, change_order_o, stall_o
    );
endinterface

// File: rtl/ip_flit_fifo.sv
// Synchronous flit FIFO with wrap-bit pointers; head is the oldest entry.
module ip_flit_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              wr_en;
    logic              rd_en;

    // Full is judged on the registered pointers, so a same-cycle pop never frees a slot early.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ip_request_ctrl.sv
// Router input port: buffers flits, XY-routes the head flit, requests the
// chosen output port and forwards the flit to the crossbar once granted.
module ip_request_ctrl
    import ip_request_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int COORD_W     = COORD_W_DEF,
    parameter int DEPTH       = 4,
    parameter int MY_X        = 0,
    parameter int MY_Y        = 0,
    parameter int STALL_LIMIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    ip_request_ctrl_if.slave    bus
);
    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0]      LIMIT_C = CW'(STALL_LIMIT);
    localparam logic [CW-1:0]      CNT_ONE = CW'(1);
    localparam logic [COORD_W-1:0] MY_X_C  = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C  = COORD_W'(MY_Y);

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              push;
    logic              pop;

    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    port_e              route_calc;

    ip_state_e         state_q, state_d;
    port_e             route_q, route_d;
    logic              grant_hit;
    logic [CW-1:0]     stall_cnt_q, stall_cnt_d;

    logic [2:0]        nexthop_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [4:0]        change_order_q;

    assign push = bus.valid_i && !fifo_full;
    assign pop  = (state_q == SEND);

    ip_flit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.data_i),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign dest_x = fifo_head[DATA_W-1 -: COORD_W];
    assign dest_y = fifo_head[DATA_W-1-COORD_W -: COORD_W];

    // Dimension-ordered routing: resolve X first, then Y.
    always_comb begin
        route_calc = PORT_L;
        if (dest_x > MY_X_C)      route_calc = PORT_E;
        else if (dest_x < MY_X_C) route_calc = PORT_W;
        else if (dest_y > MY_Y_C) route_calc = PORT_N;
        else if (dest_y < MY_Y_C) route_calc = PORT_S;
    end

    assign grant_hit = |(bus.grant_i & port_onehot(route_q));

    always_comb begin
        state_d     = state_q;
        route_d     = route_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    route_d = route_calc;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (grant_hit) begin
                    state_d     = SEND;
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != LIMIT_C) begin
                    stall_cnt_d = stall_cnt_q + CNT_ONE;
                end
            end
            SEND: begin
                state_d     = IDLE;
                stall_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so grant_i never reaches a port combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            route_q        <= PORT_NONE;
            stall_cnt_q    <= '0;
            nexthop_q      <= PORT_NONE;
            valid_q        <= 1'b0;
            data_q         <= '0;
            change_order_q <= 5'b00000;
        end else begin
            state_q        <= state_d;
            route_q        <= route_d;
            stall_cnt_q    <= stall_cnt_d;
            nexthop_q      <= (state_d == REQUEST) ? route_d : PORT_NONE;
            valid_q        <= (state_d == SEND);
            change_order_q <= (state_d == SEND) ? port_onehot(route_q) : 5'b00000;
            if (state_d == SEND) data_q <= fifo_head;
        end
    end

    assign bus.ready_o        = !fifo_full;
    assign bus.nexthop_addr_o = nexthop_q;
    assign bus.valid_o        = valid_q;
    assign bus.data_o         = data_q;
    assign bus.change_order_o = change_order_q;
    assign bus.stall_o        = (stall_cnt_q == LIMIT_C);

endmodule

// File: tb/tb_ip_request_ctrl.sv
// Directed bench for ip_request_ctrl at router (1,1) with a 4-deep FIFO.
module tb_ip_request_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    ip_request_ctrl_if #(.DATA_W(32)) bus ();

    ip_request_ctrl #(
        .DATA_W      (32),
        .COORD_W     (3),
        .DEPTH       (4),
        .MY_X        (1),
        .MY_Y        (1),
        .STALL_LIMIT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkflit(input int x, input int y, input int tag);
        logic [2:0]  xb;
        logic [2:0]  yb;
        logic [25:0] tb;
        xb = 3'(x);
        yb = 3'(y);
        tb = 26'(tag);
        return {xb, yb, tb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.valid_i = 1'b0;
        bus.grant_i = 5'b00000;
        bus.data_i  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push1(input logic [31:0] f);
        bus.valid_i = 1'b1;
        bus.data_i  = f;
        tick();
        bus.valid_i = 1'b0;
    endtask

    // Collect n flits from valid_o against exp_q, expecting a 3-cycle spacing;
    // any pending upstream flit is dropped once accepted.
    task automatic drain(input int n);
        int got = 0;
        int cyc = 0;
        int last = 0;
        bit acc;
        while (got < n && cyc < 3 * n + 12) begin
            acc = bus.valid_i && bus.ready_o;
            tick();
            cyc++;
            if (acc) bus.valid_i = 1'b0;
            if (bus.valid_o) begin
                check("drain_data", bus.data_o, exp_q.pop_front());
                if (got > 0) check("drain_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                got++;
            end
        end
        check("drain_count", 32'(got), 32'(n));
    endtask

    initial begin
        logic [31:0] f;
        reset       = 1'b1;
        bus.valid_i = 1'b0;
        bus.grant_i = 5'b00000;
        bus.data_i  = '0;

        // Reset state
        do_reset();
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_nexthop", 32'(bus.nexthop_addr_o), 32'd7);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        check("rst_change", 32'(bus.change_order_o), 32'd0);
        check("rst_stall", 32'(bus.stall_o), 32'd0);

        // Eastbound flit, granted in the first REQUEST cycle
        f = mkflit(3, 1, 32'h11);
        push1(f);
        check("e_idle_nexthop", 32'(bus.nexthop_addr_o), 32'd7);
        tick();
        check("e_req_nexthop", 32'(bus.nexthop_addr_o), 32'd3);
        check("e_req_valid", 32'(bus.valid_o), 32'd0);
        bus.grant_i = 5'b00010;
        tick();
        bus.grant_i = 5'b00000;
        check("e_send_valid", 32'(bus.valid_o), 32'd1);
        check("e_send_data", bus.data_o, f);
        check("e_send_change", 32'(bus.change_order_o), 32'b00010);
        check("e_send_nexthop", 32'(bus.nexthop_addr_o), 32'd7);
        tick();
        check("e_after_valid", 32'(bus.valid_o), 32'd0);
        check("e_after_change", 32'(bus.change_order_o), 32'd0);
        check("e_after_nexthop", 32'(bus.nexthop_addr_o), 32'd7);

        // Local flit with a grant for the wrong port held for five cycles
        f = mkflit(1, 1, 32'h22);
        push1(f);
        tick();
        check("l_req_nexthop", 32'(bus.nexthop_addr_o), 32'd4);
        bus.grant_i = 5'b00010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("l_wrong_nexthop", 32'(bus.nexthop_addr_o), 32'd4);
            check("l_wrong_valid", 32'(bus.valid_o), 32'd0);
        end
        bus.grant_i = 5'b00001;
        tick();
        bus.grant_i = 5'b00000;
        check("l_send_valid", 32'(bus.valid_o), 32'd1);
        check("l_send_change", 32'(bus.change_order_o), 32'b00001);
        check("l_send_data", bus.data_o, f);
        tick();
        check("l_after_valid", 32'(bus.valid_o), 32'd0);

        // Fill to DEPTH without grants; the fifth flit waits upstream
        do_reset();
        for (int k = 0; k < 5; k++) begin
            f = mkflit(2, 1, 32'h30 + k);
            exp_q.push_back(f);
            bus.valid_i = 1'b1;
            bus.data_i  = f;
            tick();
            check("fill_ready", 32'(bus.ready_o), (k < 3) ? 32'd1 : 32'd0);
        end
        check("fill_no_valid", 32'(bus.valid_o), 32'd0);
        bus.grant_i = 5'b00010;
        drain(5);
        bus.grant_i = 5'b00000;
        tick();
        check("fill_empty_nexthop", 32'(bus.nexthop_addr_o), 32'd7);

        // Stall detection
        do_reset();
        f = mkflit(3, 1, 32'h44);
        push1(f);
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("stall_flag", 32'(bus.stall_o), (k >= 15) ? 32'd1 : 32'd0);
        end
        bus.grant_i = 5'b00010;
        tick();
        bus.grant_i = 5'b00000;
        check("stall_send_valid", 32'(bus.valid_o), 32'd1);
        check("stall_cleared", 32'(bus.stall_o), 32'd0);
        tick();
        check("stall_idle", 32'(bus.stall_o), 32'd0);

        // Reset while requesting with two flits queued
        do_reset();
        bus.valid_i = 1'b1;
        bus.data_i  = mkflit(0, 1, 32'h51);
        tick();
        bus.data_i  = mkflit(0, 1, 32'h52);
        tick();
        bus.valid_i = 1'b0;
        check("mid_req_nexthop", 32'(bus.nexthop_addr_o), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_nexthop", 32'(bus.nexthop_addr_o), 32'd7);
        check("mid_rst_ready", 32'(bus.ready_o), 32'd1);
        check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        check("mid_rst_change", 32'(bus.change_order_o), 32'd0);
        bus.grant_i = 5'b00100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_empty_nexthop", 32'(bus.nexthop_addr_o), 32'd7);
            check("mid_empty_valid", 32'(bus.valid_o), 32'd0);
        end
        bus.grant_i = 5'b00000;

        // Push during SEND with three flits queued
        do_reset();
        for (int k = 0; k < 3; k++) begin
            f = mkflit(2, 1, 32'h60 + k);
            exp_q.push_back(f);
            push1(f);
        end
        check("pp_ready3", 32'(bus.ready_o), 32'd1);
        bus.grant_i = 5'b00010;
        tick();
        bus.grant_i = 5'b00000;
        check("pp_send_valid", 32'(bus.valid_o), 32'd1);
        check("pp_send_data", bus.data_o, exp_q.pop_front());
        f = mkflit(2, 1, 32'h63);
        exp_q.push_back(f);
        push1(f);
        check("pp_ready_after", 32'(bus.ready_o), 32'd1);
        f = mkflit(2, 1, 32'h64);
        exp_q.push_back(f);
        push1(f);
        check("pp_full", 32'(bus.ready_o), 32'd0);
        bus.grant_i = 5'b00010;
        drain(4);
        bus.grant_i = 5'b00000;
        check("pp_queue_used", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
